// File: rtl/conv_pool_rx.sv
// 2x2 max-pool receiver for a row-major conv feature map, with optional ReLU.
// Accepts one sample per non-invalid cycle and emits one result per completed window.
module conv_pool_rx #(
    parameter int unsigned data_bits   = 32,
    parameter int unsigned fmap_width  = 24,
    parameter int unsigned fmap_height = 24,
    parameter bit          relu_en     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [data_bits-1:0] in_data,
    input  logic                 in_invalid,
    input  logic                 in_finish,
    output logic [data_bits-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic                 done,
    output logic                 err_short,
    output logic                 err_extra
);

    localparam int unsigned HALF_W = fmap_width / 2;
    localparam int unsigned CW     = ($clog2(fmap_width) < 2) ? 2 : $clog2(fmap_width);
    localparam int unsigned RW     = ($clog2(fmap_height) < 1) ? 1 : $clog2(fmap_height);
    localparam int unsigned KW     = CW - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                      state, state_nxt;
    logic [CW-1:0]               col;
    logic [RW-1:0]               row;
    logic signed [data_bits-1:0] hold;
    logic signed [data_bits-1:0] linebuf [HALF_W];

    logic                        accept;
    logic                        last_sample;
    logic [KW-1:0]               k;
    logic signed [data_bits-1:0] sample;
    logic signed [data_bits-1:0] pair_max;
    logic signed [data_bits-1:0] pool_max;
    logic signed [data_bits-1:0] pool_res;

    function automatic logic signed [data_bits-1:0] smax(
        input logic signed [data_bits-1:0] a,
        input logic signed [data_bits-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // A finish flag outranks a sample offered in the same cycle, so that sample is dropped.
    assign accept      = !in_invalid && !in_finish && (state != DONE);
    assign last_sample = (col == CW'(fmap_width - 1)) && (row == RW'(fmap_height - 1));
    assign k           = col[CW-1:1];
    assign sample      = in_data;
    assign pair_max    = smax(hold, sample);
    assign pool_max    = smax(linebuf[k], pair_max);
    assign pool_res    = (relu_en && pool_max[data_bits-1]) ? '0 : pool_max;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_finish)                state_nxt = DONE;
                else if (accept)              state_nxt = last_sample ? DONE : RUN;
            end
            RUN: begin
                if (in_finish)                state_nxt = DONE;
                else if (accept && last_sample) state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, window datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            linebuf   <= '{default: '0};
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            err_short <= 1'b0;
            err_extra <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= (state == DONE);
            if (state != DONE && in_finish)   err_short <= 1'b1;
            if (state == DONE && !in_invalid) err_extra <= 1'b1;
            if (accept) begin
                if (col == CW'(fmap_width - 1)) begin
                    col <= '0;
                    row <= (row == RW'(fmap_height - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (!col[0]) begin
                    hold <= sample;
                end else if (!row[0]) begin
                    linebuf[k] <= pair_max;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= pool_res;
                    out_last  <= last_sample;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_pool_rx.sv
// Directed bench for conv_pool_rx: ramp maps, constant maps, a hand-built window,
// early finish, extra samples and mid-map reset, on a ReLU and a non-ReLU instance.
module tb_conv_pool_rx;

    localparam int W = 24;
    localparam int H = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_invalid;
    logic        in_finish;

    logic [31:0] out_data,  n_out_data;
    logic        out_valid, n_out_valid;
    logic        out_last,  n_out_last;
    logic        done,      n_done;
    logic        err_short, n_err_short;
    logic        err_extra, n_err_extra;

    int checks = 0;
    int errors = 0;

    conv_pool_rx #(.data_bits(32), .fmap_width(W), .fmap_height(H), .relu_en(1'b1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_invalid(in_invalid),
        .in_finish(in_finish), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .done(done), .err_short(err_short), .err_extra(err_extra)
    );

    conv_pool_rx #(.data_bits(32), .fmap_width(W), .fmap_height(H), .relu_en(1'b0)) dut_n (
        .clk(clk), .reset(reset), .in_data(in_data), .in_invalid(in_invalid),
        .in_finish(in_finish), .out_data(n_out_data), .out_valid(n_out_valid),
        .out_last(n_out_last), .done(n_done), .err_short(n_err_short), .err_extra(n_err_extra)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Drive one cycle's inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input int d, input logic inv);
        in_data    = 32'(d);
        in_invalid = inv;
        @(posedge clk);
        #1;
    endtask

    // Reset with a live sample offered alongside it; that sample must be dropped.
    task automatic do_reset();
        reset      = 1'b1;
        in_finish  = 1'b0;
        in_invalid = 1'b0;
        in_data    = 32'd77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset      = 1'b0;
        in_invalid = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_err_short", 32'(err_short), 32'd0);
        chk("rst_err_extra", 32'(err_extra), 32'd0);
        chk("rst_n_done",    32'(n_done),    32'd0);
    endtask

    // Full ramp map: sample (r,c) = r*W+c; window max is its bottom-right sample.
    task automatic run_ramp(input string tag);
        int nres = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cyc(r * W + c, 1'b0);
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    nres++;
                    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
                    chk({tag, "_data"},  out_data, 32'((2 * (r / 2) + 1) * W + 2 * (c / 2) + 1));
                    chk({tag, "_ndata"}, n_out_data, 32'(r * W + c));
                    chk({tag, "_last"},  32'(out_last), 32'((r == H - 1) && (c == W - 1)));
                    chk({tag, "_done_lo"}, 32'(done), 32'd0);
                end else begin
                    chk({tag, "_novalid"}, 32'(out_valid), 32'd0);
                end
            end
        end
        cyc(0, 1'b1);
        chk({tag, "_count"},     32'(nres),      32'd144);
        chk({tag, "_done"},      32'(done),      32'd1);
        chk({tag, "_end_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_err_short"}, 32'(err_short), 32'd0);
    endtask

    initial begin
        int nres;
        int nlast;
        reset = 1'b0; in_data = '0; in_invalid = 1'b1; in_finish = 1'b0;
        do_reset();

        // Ramp map, then three extra samples after completion.
        run_ramp("ramp");
        for (int i = 0; i < 3; i++) begin
            cyc(1000 + i, 1'b0);
            chk("extra_valid", 32'(out_valid), 32'd0);
            chk("extra_err",   32'(err_extra), 32'd1);
        end
        chk("extra_done",      32'(done),      32'd1);
        chk("extra_err_short", 32'(err_short), 32'd0);

        // Constant -5 map: clamped to 0 with ReLU, passed through without.
        do_reset();
        nres = 0;
        for (int i = 0; i < W * H; i++) begin
            cyc(-5, 1'b0);
            if (out_valid) begin
                nres++;
                chk("neg_relu",   out_data,   32'd0);
                chk("neg_norelu", n_out_data, 32'(-5));
            end
        end
        chk("neg_count", 32'(nres), 32'd144);

        // Hand-built windows with an idle cycle before every sample.
        do_reset();
        for (int c = 0; c < W; c++) begin
            cyc(0, 1'b1);
            chk("win_idle", 32'(out_valid), 32'd0);
            cyc((c == 0) ? 7 : (c == 1) ? -3 : (c < 4) ? -50 : 0, 1'b0);
            chk("win_row0", 32'(out_valid), 32'd0);
        end
        cyc(0, 1'b1);
        cyc(100, 1'b0);
        chk("win_even_col", 32'(out_valid), 32'd0);
        cyc(0, 1'b1);
        cyc(2, 1'b0);
        chk("win_valid", 32'(out_valid), 32'd1);
        chk("win_data",  out_data,       32'd100);
        chk("win_ndata", n_out_data,     32'd100);
        chk("win_last",  32'(out_last),  32'd0);
        cyc(0, 1'b1);
        chk("win_gap_valid", 32'(out_valid), 32'd0);
        chk("win_hold_data", out_data,       32'd100);
        cyc(-1, 1'b0);
        cyc(0, 1'b1);
        cyc(-9, 1'b0);
        chk("win2_valid",  32'(out_valid), 32'd1);
        chk("win2_relu",   out_data,       32'd0);
        chk("win2_norelu", n_out_data,     32'(-1));

        // Early finish after 300 samples: 6 pooled rows of 12 results, no last.
        do_reset();
        nres = 0; nlast = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(i, 1'b0);
            if (out_valid) nres++;
            if (out_last)  nlast++;
        end
        in_finish = 1'b1;
        cyc(5000, 1'b0);
        chk("short_err",     32'(err_short), 32'd1);
        chk("short_valid",   32'(out_valid), 32'd0);
        chk("short_done_lo", 32'(done),      32'd0);
        cyc(5001, 1'b0);
        chk("short_done",    32'(done),      32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(6000 + i, 1'b0);
            if (out_valid) nres++;
            if (out_last)  nlast++;
        end
        chk("short_count", 32'(nres),  32'd72);
        chk("short_last",  32'(nlast), 32'd0);

        // Reset partway through a map, then a clean full ramp.
        do_reset();
        for (int i = 0; i < 200; i++) cyc(i + 17, 1'b0);
        do_reset();
        run_ramp("rramp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_pool_rx.md
CONV_POOL_RX -- requirements
Module: conv_pool_rx

Interface
REQ-001 Parameter data_bits, default 32, width of the signed conv sample and pooled result.
REQ-002 Parameter fmap_width, default 24, conv output columns per row (even, >=2).
REQ-003 Parameter fmap_height, default 24, conv output rows per map (even, >=2).
REQ-004 Parameter relu_en, default 1, when 1 negative pooled results are clamped to 0.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_data  in  data_bits  signed conv sample, row-major order.
REQ-008 in_invalid  in  1  active-high "no data"; sample accepted on a clk edge with in_invalid==0.
REQ-009 in_finish  in  1  producer end-of-map flag, level, sticky until producer reset.
REQ-010 out_data  out  data_bits  signed 2x2 max-pooled (optionally ReLU) result.
REQ-011 out_valid  out  1  one-cycle pulse qualifying out_data.
REQ-012 out_last  out  1  high with out_valid on the final pooled result of the map.
REQ-013 done  out  1  high from cycle after out_last until reset.
REQ-014 err_short  out  1  sticky: in_finish seen before map complete.
REQ-015 err_extra  out  1  sticky: sample offered after map complete.

Function
REQ-016 States IDLE, RUN, DONE; IDLE->RUN on first accepted sample (which is also processed); RUN->DONE on acceptance of sample at row fmap_height-1, col fmap_width-1.
REQ-017 col counter 0..fmap_width-1 increments per accepted sample, wraps to 0 and increments row; row 0..fmap_height-1; counters hold when no sample accepted.
REQ-018 Line buffer of fmap_width/2 entries, data_bits each, indexed k=col/2.
REQ-019 Even col: sample registered into hold register.
REQ-020 Even row, odd col: linebuf[k] <= max(hold, in_data), signed compare.
REQ-021 Odd row, odd col: result = max(linebuf[k], hold, in_data); if relu_en and result<0, result=0.
REQ-022 Result drives out_data with out_valid=1 on the clk edge following acceptance (latency 1 cycle); out_valid low all other cycles.
REQ-023 out_data holds last result when out_valid==0.
REQ-024 No backpressure: one result per 4 accepted samples, max rate one result per 2 cycles; gaps in in_invalid arbitrary.
REQ-025 out_last asserted with the (fmap_height/2)*(fmap_width/2)-th result only.
REQ-026 done rises cycle after out_last, stays 1 until reset.
REQ-027 in_finish==1 while in IDLE or RUN -> err_short<=1, state DONE, done<=1 next cycle, no further outputs; in-progress partial windows discarded.
REQ-028 In DONE, any sample with in_invalid==0 is ignored and sets err_extra<=1.
REQ-029 in_finish==1 in DONE is normal, no error.
REQ-030 Signed compare on full data_bits; equal values return either operand (identical result).

Reset
REQ-031 reset==1 on clk edge: state IDLE, col=0, row=0, hold=0, all linebuf entries=0, out_data=0, out_valid=0, out_last=0, done=0, err_short=0, err_extra=0.
REQ-032 reset has priority over a simultaneously accepted sample; that sample is dropped.
REQ-033 reset mid-map aborts map; next accepted sample is treated as row 0, col 0.

Verification
REQ-034 Ramp map W=H=24, in_data=row*24+col, in_invalid=0 continuously -> 144 results, result(r,c)=(2r+1)*24+2c+1, out_valid 1 cycle after each odd-row odd-col sample, out_last on 144th, done next cycle.
REQ-035 All samples -5, relu_en=1 -> 144 results of 0; relu_en=0 -> 144 results of -5.
REQ-036 Window {7,-3,100,2} (max in odd row, even col), in_invalid toggling 1,0 every cycle -> out_data=100, counters unaffected by idle cycles.
REQ-037 in_finish asserted after 300 samples -> err_short=1, done=1, exactly 6*12=72 results emitted, no out_last.
REQ-038 Full map then 3 more samples with in_invalid=0 -> err_extra=1, no extra out_valid.
REQ-039 reset asserted at sample 200, then full ramp map -> all flags 0 after reset, 144 correct results as REQ-034.
